// File: rtl/ast_pkg.sv
// Shared definitions for the ast pulse send/receive logic.
// FSM encoding, status bit positions and the polarity bit of cfg_pol.
package ast_pkg;

  typedef enum logic [1:0] {
    ST_ARM    = 2'd0,
    ST_IDLE   = 2'd1,
    ST_ACTIVE = 2'd2,
    ST_STUCK  = 2'd3
  } ast_st_e;

  localparam int STU_OK    = 0;
  localparam int STU_SHORT = 1;
  localparam int STU_LONG  = 2;
  localparam int STU_ARMED = 3;

  // cfg_pol[POL_BIT] = POL_ACT_HIGH selects an active-high pulse
  localparam int   POL_BIT      = 0;
  localparam logic POL_ACT_HIGH = 1'b1;

endpackage

// File: rtl/ast_sync_flt.sv
// Purpose: 2-FF synchroniser plus FLT_LEN run-length deglitch filter for the ast line.
// Latency: 2 + FLT_LEN cycles from ast_in to filt.
// Backpressure: none; stable flags that filt reflects a settled, genuinely sampled line.
module ast_sync_flt #(
  parameter int FLT_LEN = 3
) (
  input  logic clk_sys,
  input  logic rst_n,
  input  logic ast_in,
  output logic filt,
  output logic stable
);

  localparam int CW = $clog2(FLT_LEN);

  logic          sync1;
  logic          sync2;
  logic [1:0]    prime;
  logic [CW-1:0] run;

  always_ff @(posedge clk_sys or negedge rst_n) begin
    if (!rst_n) begin
      sync1 <= 1'b0;
      sync2 <= 1'b0;
      prime <= 2'b00;
      run   <= '0;
      filt  <= 1'b0;
    end else begin
      sync1 <= ast_in;
      sync2 <= sync1;
      prime <= {prime[0], 1'b1};
      if (sync2 == filt) begin
        run <= '0;
      end else if (run == CW'(FLT_LEN - 1)) begin
        filt <= sync2;
        run  <= '0;
      end else begin
        run <= run + CW'(1);
      end
    end
  end

  // Until the sync chain holds a real sample, the reset value of filt means nothing
  assign stable = prime[1] && (sync2 == filt);

endmodule

// File: rtl/ast_recv.sv
// Purpose: receive-side ast pulse measurement and classification with sticky status.
// Latency: outputs update one cycle after the filtered edge (2 + FLT_LEN + 1 from the pin).
// Backpressure: none; ast_det is a one-cycle strobe, status is held for register readback.
module ast_recv
  import ast_pkg::*;
#(
  parameter int FLT_LEN = 3
) (
  input  logic       clk_sys,
  input  logic       rst_n,
  input  logic       pluse_us,
  input  logic       ast_in,
  input  logic [7:0] cfg_pol,
  input  logic [7:0] cfg_width,
  input  logic [7:0] cfg_tol,
  output logic       ast_det,
  output logic [7:0] ast_width,
  output logic [7:0] stu_ast,
  output logic [7:0] cnt_ast,
  output logic       ast_busy,
  input  logic       clr_stu
);

  logic       filt;
  logic       flt_stable;
  logic       filt_q;
  ast_st_e    state_q, state_d;
  logic       pol_q, pol_d;
  logic [7:0] wcnt_q, wcnt_d, wcnt_inc;
  logic [7:0] width_d, cnt_d;
  logic [3:0] stu_q, stu_d;
  logic       det_d;
  logic       pol_cur, lvl_act, lead;
  logic [8:0] diff9, sum9;
  logic [7:0] w_min, w_max;
  logic       unused_pol;

  ast_sync_flt #(.FLT_LEN(FLT_LEN)) u_sync_flt (
    .clk_sys (clk_sys),
    .rst_n   (rst_n),
    .ast_in  (ast_in),
    .filt    (filt),
    .stable  (flt_stable)
  );

  assign unused_pol = ^cfg_pol[7:1];

  assign diff9 = {1'b0, cfg_width} - {1'b0, cfg_tol};
  assign sum9  = {1'b0, cfg_width} + {1'b0, cfg_tol};
  assign w_min = diff9[8] ? 8'd0  : diff9[7:0];
  assign w_max = sum9[8]  ? 8'hFF : sum9[7:0];

  assign ast_busy = (state_q == ST_ACTIVE) || (state_q == ST_STUCK);
  // Polarity is frozen for the whole pulse so a mid-pulse config write cannot split it
  assign pol_cur  = ast_busy ? pol_q : cfg_pol[POL_BIT];
  assign lvl_act  = filt ^ ~pol_cur;
  assign lead     = lvl_act && (filt != filt_q);
  assign wcnt_inc = (pluse_us && (wcnt_q != 8'hFF)) ? wcnt_q + 8'd1 : wcnt_q;
  assign stu_ast  = {4'b0000, stu_q};

  always_comb begin
    state_d = state_q;
    pol_d   = pol_q;
    wcnt_d  = wcnt_q;
    width_d = ast_width;
    det_d   = 1'b0;
    stu_d   = clr_stu ? (stu_q & 4'b1000) : stu_q;
    cnt_d   = clr_stu ? 8'd0 : cnt_ast;
    case (state_q)
      ST_ARM: begin
        if (flt_stable && !lvl_act) begin
          state_d          = ST_IDLE;
          stu_d[STU_ARMED] = 1'b1;
        end
      end
      ST_IDLE: begin
        if (lead) begin
          state_d = ST_ACTIVE;
          wcnt_d  = 8'd0;
          pol_d   = cfg_pol[POL_BIT];
        end
      end
      ST_ACTIVE: begin
        if (!lvl_act) begin
          state_d = ST_IDLE;
          width_d = wcnt_q;
          if (wcnt_q < w_min) begin
            stu_d[STU_SHORT] = 1'b1;
            stu_d[STU_OK]    = 1'b0;
          end else if (wcnt_q > w_max) begin
            stu_d[STU_LONG] = 1'b1;
            stu_d[STU_OK]   = 1'b0;
          end else begin
            stu_d[STU_OK] = 1'b1;
            det_d         = 1'b1;
            cnt_d         = cnt_d + 8'd1;
          end
        end else if (wcnt_q > w_max) begin
          state_d          = ST_STUCK;
          width_d          = wcnt_q;
          stu_d[STU_LONG]  = 1'b1;
          stu_d[STU_OK]    = 1'b0;
          wcnt_d           = wcnt_inc;
        end else begin
          wcnt_d = wcnt_inc;
        end
      end
      ST_STUCK: begin
        if (!lvl_act) state_d = ST_IDLE;
        else          wcnt_d  = wcnt_inc;
      end
      default: state_d = ST_ARM;
    endcase
  end

  always_ff @(posedge clk_sys or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= ST_ARM;
      filt_q    <= 1'b0;
      pol_q     <= 1'b0;
      wcnt_q    <= 8'd0;
      stu_q     <= 4'd0;
      ast_det   <= 1'b0;
      ast_width <= 8'd0;
      cnt_ast   <= 8'd0;
    end else begin
      state_q   <= state_d;
      filt_q    <= filt;
      pol_q     <= pol_d;
      wcnt_q    <= wcnt_d;
      stu_q     <= stu_d;
      ast_det   <= det_d;
      ast_width <= width_d;
      cnt_ast   <= cnt_d;
    end
  end

endmodule

// File: tb/tb_ast_recv.sv
// Directed bench for ast_recv: table of single pulses plus hand sequences for stuck, reset, polarity and wrap.
module tb_ast_recv;

  logic       clk_sys = 1'b0;
  logic       rst_n;
  logic       pluse_us;
  logic       ast_in;
  logic [7:0] cfg_pol, cfg_width, cfg_tol;
  logic       clr_stu;
  logic       ast_det, ast_busy;
  logic [7:0] ast_width, stu_ast, cnt_ast;

  int errors = 0;
  int checks = 0;
  int pcnt = 0;
  int det_cnt = 0;
  int busy_seen = 0;

  typedef struct {
    logic       clr;
    logic [7:0] width;
    logic [7:0] tol;
    int         n_us;
    int         exp_det;
    logic [7:0] exp_width;
    logic [7:0] exp_stu;
    logic [7:0] exp_cnt;
  } vec_t;

  vec_t vecs[6];

  ast_recv #(.FLT_LEN(3)) dut (
    .clk_sys   (clk_sys),
    .rst_n     (rst_n),
    .pluse_us  (pluse_us),
    .ast_in    (ast_in),
    .cfg_pol   (cfg_pol),
    .cfg_width (cfg_width),
    .cfg_tol   (cfg_tol),
    .ast_det   (ast_det),
    .ast_width (ast_width),
    .stu_ast   (stu_ast),
    .cnt_ast   (cnt_ast),
    .ast_busy  (ast_busy),
    .clr_stu   (clr_stu)
  );

  always #5 clk_sys = ~clk_sys;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // One cycle: a microsecond is 4 clocks, pluse_us high when pcnt wraps to 0
  task automatic tick();
    @(negedge clk_sys);
    pcnt     = (pcnt == 3) ? 0 : pcnt + 1;
    pluse_us = (pcnt == 0);
    if (ast_det)  det_cnt++;
    if (ast_busy) busy_seen++;
  endtask

  // Pulse of n_us microseconds, phase-aligned so the leading/trailing FSM cycles fall between strobes
  task automatic pulse(input logic act, input int n_us, input bit clr_trail);
    det_cnt   = 0;
    busy_seen = 0;
    do tick(); while (pcnt != 1);
    ast_in = act;
    repeat (n_us * 4) tick();
    ast_in = ~act;
    if (clr_trail) begin
      repeat (5) tick();
      clr_stu = 1'b1;
      tick();
      clr_stu = 1'b0;
      repeat (6) tick();
    end else begin
      repeat (12) tick();
    end
  endtask

  task automatic hard_reset();
    @(negedge clk_sys);
    rst_n = 1'b0;
    repeat (3) tick();
    rst_n = 1'b1;
    repeat (20) tick();
  endtask

  task automatic clear();
    clr_stu = 1'b1;
    tick();
    clr_stu = 1'b0;
    tick();
  endtask

  initial begin
    vecs[0] = '{1'b1, 8'd10,  8'd2,  10, 1, 8'd10, 8'h09, 8'd1};
    vecs[1] = '{1'b1, 8'd10,  8'd2,  7,  0, 8'd7,  8'h0A, 8'd0};
    vecs[2] = '{1'b0, 8'd10,  8'd2,  12, 1, 8'd12, 8'h0B, 8'd1};
    vecs[3] = '{1'b1, 8'd10,  8'd2,  8,  1, 8'd8,  8'h09, 8'd1};
    vecs[4] = '{1'b0, 8'd3,   8'd5,  1,  1, 8'd1,  8'h09, 8'd2};
    vecs[5] = '{1'b0, 8'd250, 8'd10, 2,  0, 8'd2,  8'h0A, 8'd2};

    rst_n = 1'b0; pluse_us = 1'b0; ast_in = 1'b0; clr_stu = 1'b0;
    cfg_pol = 8'h01; cfg_width = 8'd10; cfg_tol = 8'd2;
    repeat (3) tick();
    check("rst_det", ast_det, 0);
    check("rst_width", ast_width, 0);
    check("rst_stu", stu_ast, 0);
    check("rst_cnt", cnt_ast, 0);
    check("rst_busy", ast_busy, 0);
    rst_n = 1'b1;
    repeat (20) tick();
    check("armed_stu", stu_ast, 8'h08);

    for (int i = 0; i < 6; i++) begin
      cfg_width = vecs[i].width;
      cfg_tol   = vecs[i].tol;
      if (vecs[i].clr) clear();
      pulse(1'b1, vecs[i].n_us, 1'b0);
      check($sformatf("v%0d_det", i), det_cnt, vecs[i].exp_det);
      check($sformatf("v%0d_width", i), ast_width, vecs[i].exp_width);
      check($sformatf("v%0d_stu", i), stu_ast, vecs[i].exp_stu);
      check($sformatf("v%0d_cnt", i), cnt_ast, vecs[i].exp_cnt);
    end

    // Stuck line: 5us +/-0 held for 20us
    cfg_width = 8'd5; cfg_tol = 8'd0;
    clear();
    det_cnt = 0;
    do tick(); while (pcnt != 1);
    ast_in = 1'b1;
    repeat (48) tick();
    check("stuck_busy_mid", ast_busy, 1);
    check("stuck_bit2_mid", stu_ast[2], 1);
    check("stuck_width_mid", ast_width, 6);
    repeat (32) tick();
    ast_in = 1'b0;
    repeat (12) tick();
    check("stuck_busy_end", ast_busy, 0);
    check("stuck_det", det_cnt, 0);
    check("stuck_width_end", ast_width, 6);
    check("stuck_stu", stu_ast, 8'h0C);
    check("stuck_cnt", cnt_ast, 0);

    // Line active through reset release must never be counted
    cfg_width = 8'd10; cfg_tol = 8'd2;
    ast_in = 1'b1;
    hard_reset();
    repeat (20) tick();
    check("arm_held_stu", stu_ast, 0);
    check("arm_held_busy", ast_busy, 0);
    ast_in = 1'b0;
    repeat (20) tick();
    check("arm_release_stu", stu_ast, 8'h08);
    pulse(1'b1, 10, 1'b0);
    check("arm_pulse_cnt", cnt_ast, 1);

    // Reset mid-pulse
    do tick(); while (pcnt != 1);
    ast_in = 1'b1;
    repeat (20) tick();
    check("midrst_busy_pre", ast_busy, 1);
    #3 rst_n = 1'b0;
    #1;
    check("midrst_busy", ast_busy, 0);
    check("midrst_stu", stu_ast, 0);
    check("midrst_cnt", cnt_ast, 0);
    check("midrst_width", ast_width, 0);
    check("midrst_det", ast_det, 0);
    repeat (2) tick();
    rst_n = 1'b1;
    repeat (20) tick();
    check("midrst_arm_stu", stu_ast, 0);
    ast_in = 1'b0;
    repeat (20) tick();

    // Active-low polarity with glitch rejection
    cfg_pol = 8'hFE; cfg_width = 8'd4; cfg_tol = 8'd0;
    ast_in = 1'b1;
    hard_reset();
    check("pol_arm_stu", stu_ast, 8'h08);
    busy_seen = 0;
    for (int g = 0; g < 2; g++) begin
      ast_in = 1'b0;
      repeat (2) tick();
      ast_in = 1'b1;
      repeat (10) tick();
    end
    check("glitch_busy", busy_seen, 0);
    check("glitch_stu", stu_ast, 8'h08);
    check("glitch_cnt", cnt_ast, 0);
    pulse(1'b0, 4, 1'b0);
    check("pol_det", det_cnt, 1);
    check("pol_width", ast_width, 4);
    check("pol_stu", stu_ast, 8'h09);
    check("pol_cnt", cnt_ast, 1);

    // Counter wrap, then clr_stu coincident with an accepted trailing edge
    cfg_pol = 8'h01; cfg_width = 8'd2; cfg_tol = 8'd2;
    ast_in = 1'b0;
    hard_reset();
    for (int p = 0; p < 255; p++) pulse(1'b1, 1, 1'b0);
    check("wrap_cnt_255", cnt_ast, 255);
    pulse(1'b1, 1, 1'b0);
    check("wrap_cnt_0", cnt_ast, 0);
    check("wrap_stu", stu_ast, 8'h09);
    pulse(1'b1, 1, 1'b0);
    cfg_width = 8'd6; cfg_tol = 8'd1;
    pulse(1'b1, 1, 1'b0);
    check("preclr_stu", stu_ast, 8'h0A);
    check("preclr_cnt", cnt_ast, 1);
    cfg_width = 8'd2; cfg_tol = 8'd2;
    pulse(1'b1, 1, 1'b1);
    check("clrhit_det", det_cnt, 1);
    check("clrhit_cnt", cnt_ast, 1);
    check("clrhit_stu", stu_ast, 8'h09);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
